// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline registers: register-field width,
// the hard-wired zero register, ALU op width and the execute-stage control bundle.
package mips_pkg;

    localparam int REG_W = 5;
    localparam int ALU_W = 3;

    localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

    // Control that travels with an instruction into execute. Kept as one packed
    // struct so a bubble can be inserted with a single assignment.
    typedef struct packed {
        logic             reg_write;
        logic             memto_reg;
        logic             mem_write;
        logic             alu_src;
        logic             reg_dst;
        logic [ALU_W-1:0] alu_control;
    } ctrl_e_t;

    localparam ctrl_e_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/bubble_watchdog.sv
// Consecutive-bubble watchdog for the decode-to-execute register.
// Counts back-to-back flush edges (saturating), clears on a real instruction
// entering execute, and raises a sticky flag once the run reaches MAX_BUBBLES.
module bubble_watchdog #(
    parameter int MAX_BUBBLES = 8,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             stall,
    input  logic             capture_valid,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic             stuck_err
);

    localparam logic [CNT_W-1:0] CNT_SAT = '1;
    localparam logic [CNT_W-1:0] CNT_TRIP = CNT_W'(MAX_BUBBLES);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             stuck_q;

    // Next count on a flush edge, pinned at the saturation value.
    always_comb begin
        cnt_inc = cnt_q;
        if (cnt_q != CNT_SAT) begin
            cnt_inc = cnt_q + CNT_W'(1);
        end
    end

    // Flush takes priority over stall; a stalled cycle freezes the run length.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            stuck_q <= 1'b0;
        end else if (flush) begin
            cnt_q <= cnt_inc;
            if (cnt_inc == CNT_TRIP) begin
                stuck_q <= 1'b1;
            end
        end else if (!stall && capture_valid) begin
            cnt_q <= '0;
        end
    end

    assign bubble_cnt = cnt_q;
    assign stuck_err  = stuck_q;

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with flush, stall hold, valid tracking
// and a consecutive-bubble watchdog.
// Optional build macro ID_EX_PERF_EN adds free-running bubble/instruction
// counters (bubble_count, instr_count).
//
// Handshake: there is no valid/ready pair here. The hazard unit owns flow:
// FlushE inserts a bubble and wins over StallE; StallE holds E; otherwise
// every edge captures the decode slot, tagged by validD.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int MAX_BUBBLES = 8,
    parameter int CNT_W       = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              FlushE,
    input  logic              StallE,
    input  logic              validD,
    input  logic              RegWriteD,
    input  logic              MemtoRegD,
    input  logic              MemWriteD,
    input  logic              ALUSrcD,
    input  logic              RegDstD,
    input  logic [ALU_W-1:0]  ALUControlD,
    input  logic [DATA_W-1:0] RD1D,
    input  logic [DATA_W-1:0] RD2D,
    input  logic [DATA_W-1:0] RD3D,
    input  logic [DATA_W-1:0] SignImmD,
    input  logic [DATA_W-1:0] PCPlus4D,
    input  logic [REG_W-1:0]  rsD,
    input  logic [REG_W-1:0]  rtD,
    input  logic [REG_W-1:0]  rdD,
    output logic              RegWriteE,
    output logic              MemtoRegE,
    output logic              MemWriteE,
    output logic              ALUSrcE,
    output logic              RegDstE,
    output logic [ALU_W-1:0]  ALUControlE,
    output logic [DATA_W-1:0] RD1E,
    output logic [DATA_W-1:0] RD2E,
    output logic [DATA_W-1:0] RD3E,
    output logic [DATA_W-1:0] SignImmE,
    output logic [DATA_W-1:0] PCPlus4E,
    output logic [REG_W-1:0]  rsE,
    output logic [REG_W-1:0]  rtE,
    output logic [REG_W-1:0]  rdE,
    output logic [REG_W-1:0]  WriteRegE,
    output logic              validE,
`ifdef ID_EX_PERF_EN
    output logic [31:0]       bubble_count,
    output logic [31:0]       instr_count,
`endif
    output logic              stuck_err
);

    ctrl_e_t           ctrl_d;
    ctrl_e_t           ctrl_q;
    logic [DATA_W-1:0] rd1_q;
    logic [DATA_W-1:0] rd2_q;
    logic [DATA_W-1:0] rd3_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] pc4_q;
    logic [REG_W-1:0]  rs_q;
    logic [REG_W-1:0]  rt_q;
    logic [REG_W-1:0]  rd_q;
    logic              valid_q;
    logic [CNT_W-1:0]  bubble_cnt;

    // Bundle decode control; a non-instruction slot enters E as a bubble.
    always_comb begin
        ctrl_d = CTRL_BUBBLE;
        if (validD) begin
            ctrl_d.reg_write   = RegWriteD;
            ctrl_d.memto_reg   = MemtoRegD;
            ctrl_d.mem_write   = MemWriteD;
            ctrl_d.alu_src     = ALUSrcD;
            ctrl_d.reg_dst     = RegDstD;
            ctrl_d.alu_control = ALUControlD;
        end
    end

    // Pipeline register: flush clears everything (zero register fields can never
    // match a forwarding source), stall holds, otherwise capture decode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q  <= CTRL_BUBBLE;
            rd1_q   <= '0;
            rd2_q   <= '0;
            rd3_q   <= '0;
            imm_q   <= '0;
            pc4_q   <= '0;
            rs_q    <= ZERO_REG;
            rt_q    <= ZERO_REG;
            rd_q    <= ZERO_REG;
            valid_q <= 1'b0;
        end else if (FlushE) begin
            ctrl_q  <= CTRL_BUBBLE;
            rd1_q   <= '0;
            rd2_q   <= '0;
            rd3_q   <= '0;
            imm_q   <= '0;
            pc4_q   <= '0;
            rs_q    <= ZERO_REG;
            rt_q    <= ZERO_REG;
            rd_q    <= ZERO_REG;
            valid_q <= 1'b0;
        end else if (!StallE) begin
            ctrl_q  <= ctrl_d;
            rd1_q   <= RD1D;
            rd2_q   <= RD2D;
            rd3_q   <= RD3D;
            imm_q   <= SignImmD;
            pc4_q   <= PCPlus4D;
            rs_q    <= rsD;
            rt_q    <= rtD;
            rd_q    <= rdD;
            valid_q <= validD;
        end
    end

    bubble_watchdog #(
        .MAX_BUBBLES (MAX_BUBBLES),
        .CNT_W       (CNT_W)
    ) u_watchdog (
        .clk           (clk),
        .reset         (reset),
        .flush         (FlushE),
        .stall         (StallE),
        .capture_valid (validD),
        .bubble_cnt    (bubble_cnt),
        .stuck_err     (stuck_err)
    );

    // The count is only consumed inside the watchdog; keep it visible for probing.
    logic unused_cnt;
    assign unused_cnt = ^bubble_cnt;

`ifdef ID_EX_PERF_EN
    logic [31:0] bubble_count_q;
    logic [31:0] instr_count_q;

    // Free-running event counters; wrap naturally at 2^32.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bubble_count_q <= '0;
            instr_count_q  <= '0;
        end else if (FlushE) begin
            bubble_count_q <= bubble_count_q + 32'd1;
        end else if (!StallE && validD) begin
            instr_count_q <= instr_count_q + 32'd1;
        end
    end

    assign bubble_count = bubble_count_q;
    assign instr_count  = instr_count_q;
`endif

    assign RegWriteE   = ctrl_q.reg_write;
    assign MemtoRegE   = ctrl_q.memto_reg;
    assign MemWriteE   = ctrl_q.mem_write;
    assign ALUSrcE     = ctrl_q.alu_src;
    assign RegDstE     = ctrl_q.reg_dst;
    assign ALUControlE = ctrl_q.alu_control;
    assign RD1E        = rd1_q;
    assign RD2E        = rd2_q;
    assign RD3E        = rd3_q;
    assign SignImmE    = imm_q;
    assign PCPlus4E    = pc4_q;
    assign rsE         = rs_q;
    assign rtE         = rt_q;
    assign rdE         = rd_q;
    assign validE      = valid_q;
    assign WriteRegE   = ctrl_q.reg_dst ? rd_q : rt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: a reference model of the E register
// contents plus directed scenarios with literal expectations.
module tb_id_ex_stage;

    localparam int DATA_W      = 32;
    localparam int MAX_BUBBLES = 8;
    localparam int CNT_W       = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        FlushE, StallE, validD;
    logic        RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD;
    logic [2:0]  ALUControlD;
    logic [31:0] RD1D, RD2D, RD3D, SignImmD, PCPlus4D;
    logic [4:0]  rsD, rtD, rdD;
    logic        RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, RD3E, SignImmE, PCPlus4E;
    logic [4:0]  rsE, rtE, rdE, WriteRegE;
    logic        validE, stuck_err;
`ifdef ID_EX_PERF_EN
    logic [31:0] bubble_count, instr_count;
`endif

    id_ex_stage #(
        .DATA_W(DATA_W), .MAX_BUBBLES(MAX_BUBBLES), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .FlushE(FlushE), .StallE(StallE), .validD(validD),
        .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
        .ALUSrcD(ALUSrcD), .RegDstD(RegDstD), .ALUControlD(ALUControlD),
        .RD1D(RD1D), .RD2D(RD2D), .RD3D(RD3D), .SignImmD(SignImmD), .PCPlus4D(PCPlus4D),
        .rsD(rsD), .rtD(rtD), .rdD(rdD),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
        .ALUSrcE(ALUSrcE), .RegDstE(RegDstE), .ALUControlE(ALUControlE),
        .RD1E(RD1E), .RD2E(RD2E), .RD3E(RD3E), .SignImmE(SignImmE), .PCPlus4E(PCPlus4E),
        .rsE(rsE), .rtE(rtE), .rdE(rdE), .WriteRegE(WriteRegE), .validE(validE),
`ifdef ID_EX_PERF_EN
        .bubble_count(bubble_count), .instr_count(instr_count),
`endif
        .stuck_err(stuck_err)
    );

    // ---------------- counters / check helper ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // E contents as one record: an instruction in E is either a real one copied
    // from decode, a data-only slot with no control, or an all-zero bubble.
    typedef struct {
        logic        rw, m2r, mw, asrc, rdst;
        logic [2:0]  aluc;
        logic [31:0] rd1, rd2, rd3, imm, pc4;
        logic [4:0]  rs, rt, rd;
        logic        valid;
    } e_rec_t;

    e_rec_t m;
    int     flush_run;   // flush edges since the last real instruction entered E
    bit     m_stuck;
    longint m_bubbles, m_instrs;

    function automatic e_rec_t zero_rec();
        e_rec_t r;
        r.rw = 0; r.m2r = 0; r.mw = 0; r.asrc = 0; r.rdst = 0; r.aluc = 0;
        r.rd1 = 0; r.rd2 = 0; r.rd3 = 0; r.imm = 0; r.pc4 = 0;
        r.rs = 0; r.rt = 0; r.rd = 0; r.valid = 0;
        return r;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m = zero_rec(); flush_run = 0; m_stuck = 0; m_bubbles = 0; m_instrs = 0;
        end else if (FlushE) begin
            m = zero_rec();
            flush_run++;
            if (flush_run == MAX_BUBBLES) m_stuck = 1;
            m_bubbles++;
        end else if (!StallE) begin
            m.rd1 = RD1D; m.rd2 = RD2D; m.rd3 = RD3D; m.imm = SignImmD; m.pc4 = PCPlus4D;
            m.rs = rsD; m.rt = rtD; m.rd = rdD; m.valid = validD;
            if (validD) begin
                m.rw = RegWriteD; m.m2r = MemtoRegD; m.mw = MemWriteD;
                m.asrc = ALUSrcD; m.rdst = RegDstD; m.aluc = ALUControlD;
                flush_run = 0;
                m_instrs++;
            end else begin
                m.rw = 0; m.m2r = 0; m.mw = 0; m.asrc = 0; m.rdst = 0; m.aluc = 0;
            end
        end
    end

    // ---------------- scoreboard: compare every cycle ----------------
    bit mon_en = 0;
    always @(negedge clk) begin
        if (mon_en) begin
            chk("m_RegWriteE", 32'(RegWriteE), 32'(m.rw));
            chk("m_MemtoRegE", 32'(MemtoRegE), 32'(m.m2r));
            chk("m_MemWriteE", 32'(MemWriteE), 32'(m.mw));
            chk("m_ALUSrcE", 32'(ALUSrcE), 32'(m.asrc));
            chk("m_RegDstE", 32'(RegDstE), 32'(m.rdst));
            chk("m_ALUControlE", 32'(ALUControlE), 32'(m.aluc));
            chk("m_RD1E", RD1E, m.rd1);
            chk("m_RD2E", RD2E, m.rd2);
            chk("m_RD3E", RD3E, m.rd3);
            chk("m_SignImmE", SignImmE, m.imm);
            chk("m_PCPlus4E", PCPlus4E, m.pc4);
            chk("m_rsE", 32'(rsE), 32'(m.rs));
            chk("m_rtE", 32'(rtE), 32'(m.rt));
            chk("m_rdE", 32'(rdE), 32'(m.rd));
            chk("m_WriteRegE", 32'(WriteRegE), 32'(m.rdst ? m.rd : m.rt));
            chk("m_validE", 32'(validE), 32'(m.valid));
            chk("m_stuck_err", 32'(stuck_err), 32'(m_stuck));
`ifdef ID_EX_PERF_EN
            chk("m_bubble_count", bubble_count, m_bubbles[31:0]);
            chk("m_instr_count", instr_count, m_instrs[31:0]);
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        FlushE = 0; StallE = 0; validD = 0;
        RegWriteD = 0; MemtoRegD = 0; MemWriteD = 0; ALUSrcD = 0; RegDstD = 0;
        ALUControlD = 0; RD1D = 0; RD2D = 0; RD3D = 0; SignImmD = 0; PCPlus4D = 0;
        rsD = 0; rtD = 0; rdD = 0;
    endtask

    // One rising edge, returning at the following falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                               input logic rdst, input logic m2r);
        idle_inputs();
        validD = 1; RegWriteD = 1; RegDstD = rdst; MemtoRegD = m2r;
        rsD = rs; rtD = rt; rdD = rd;
    endtask

    task automatic flushes(input int n);
        for (int i = 0; i < n; i++) begin
            idle_inputs(); FlushE = 1; cyc();
        end
        FlushE = 0;
    endtask

    task automatic async_reset_pulse();
        #2 reset = 0;
        #1;
        chk("async_validE", 32'(validE), 32'd0);
        chk("async_RD1E", RD1E, 32'd0);
        chk("async_WriteRegE", 32'(WriteRegE), 32'd0);
        chk("async_stuck_err", 32'(stuck_err), 32'd0);
        #1 reset = 1;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        idle_inputs();
        repeat (2) @(negedge clk);
        mon_en = 1;
        @(negedge clk);
        chk("reset_validE", 32'(validE), 32'd0);
        chk("reset_WriteRegE", 32'(WriteRegE), 32'd0);
        chk("reset_stuck_err", 32'(stuck_err), 32'd0);
        reset = 1;

        // Reset then capture
        drive_instr(5'd3, 5'd4, 5'd5, 1'b1, 1'b0);
        RD1D = 32'h1234;
        cyc();
        chk("cap_rsE", 32'(rsE), 32'd3);
        chk("cap_WriteRegE", 32'(WriteRegE), 32'd5);
        chk("cap_RegWriteE", 32'(RegWriteE), 32'd1);
        chk("cap_RD1E", RD1E, 32'h1234);
        chk("cap_validE", 32'(validE), 32'd1);

        // Flush bubble behind a lw
        drive_instr(5'd2, 5'd8, 5'd0, 1'b0, 1'b1);
        cyc();
        chk("lw_MemtoRegE", 32'(MemtoRegE), 32'd1);
        chk("lw_rtE", 32'(rtE), 32'd8);
        chk("lw_WriteRegE", 32'(WriteRegE), 32'd8);
        FlushE = 1;
        cyc();
        FlushE = 0;
        chk("flush_MemtoRegE", 32'(MemtoRegE), 32'd0);
        chk("flush_RegWriteE", 32'(RegWriteE), 32'd0);
        chk("flush_rsE", 32'(rsE), 32'd0);
        chk("flush_rtE", 32'(rtE), 32'd0);
        chk("flush_WriteRegE", 32'(WriteRegE), 32'd0);
        chk("flush_validE", 32'(validE), 32'd0);

        // Stall hold, then flush beats stall
        drive_instr(5'd1, 5'd9, 5'd0, 1'b0, 1'b0);
        cyc();
        chk("pre_stall_rtE", 32'(rtE), 32'd9);
        rtD = 5'd10; StallE = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_rtE", 32'(rtE), 32'd9);
            chk("stall_validE", 32'(validE), 32'd1);
        end
        FlushE = 1;
        cyc();
        FlushE = 0; StallE = 0;
        chk("stallflush_rtE", 32'(rtE), 32'd0);
        chk("stallflush_validE", 32'(validE), 32'd0);

        // validD=0 capture: data moves, control does not
        idle_inputs();
        RegWriteD = 1; MemWriteD = 1; RD2D = 32'hABCD; rtD = 5'd7;
        cyc();
        chk("nv_RegWriteE", 32'(RegWriteE), 32'd0);
        chk("nv_MemWriteE", 32'(MemWriteE), 32'd0);
        chk("nv_RD2E", RD2E, 32'hABCD);
        chk("nv_rtE", 32'(rtE), 32'd7);
        chk("nv_validE", 32'(validE), 32'd0);

        // Watchdog trips on exactly the MAX_BUBBLES-th flush
        drive_instr(5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
        cyc();
        flushes(MAX_BUBBLES - 1);
        chk("wd_before_trip", 32'(stuck_err), 32'd0);
        flushes(1);
        chk("wd_trip", 32'(stuck_err), 32'd1);
        drive_instr(5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
        cyc();
        chk("wd_sticky", 32'(stuck_err), 32'd1);
        chk("wd_sticky_validE", 32'(validE), 32'd1);
        async_reset_pulse();
        @(negedge clk);
        chk("wd_reset_clear", 32'(stuck_err), 32'd0);

        // Watchdog clears on a real instruction between runs
        flushes(MAX_BUBBLES - 1);
        drive_instr(5'd4, 5'd5, 5'd6, 1'b1, 1'b0);
        cyc();
        flushes(MAX_BUBBLES - 1);
        chk("wd_clear_no_trip", 32'(stuck_err), 32'd0);

        // Async reset while a real instruction sits in E; next edge captures
        drive_instr(5'd11, 5'd12, 5'd13, 1'b1, 1'b0);
        RD1D = 32'hDEAD_BEEF;
        cyc();
        chk("pre_async_validE", 32'(validE), 32'd1);
        async_reset_pulse();
        drive_instr(5'd14, 5'd15, 5'd16, 1'b0, 1'b0);
        cyc();
        chk("post_reset_rtE", 32'(rtE), 32'd15);
        chk("post_reset_WriteRegE", 32'(WriteRegE), 32'd15);
        chk("post_reset_validE", 32'(validE), 32'd1);

        // Mixed traffic checked by the model alone
        for (int i = 0; i < 60; i++) begin
            FlushE = ($urandom_range(0, 5) == 0);
            StallE = ($urandom_range(0, 4) == 0);
            validD = ($urandom_range(0, 3) != 0);
            RegWriteD = 1'($urandom_range(0, 1));
            MemtoRegD = 1'($urandom_range(0, 1));
            MemWriteD = 1'($urandom_range(0, 1));
            ALUSrcD = 1'($urandom_range(0, 1));
            RegDstD = 1'($urandom_range(0, 1));
            ALUControlD = 3'($urandom_range(0, 7));
            RD1D = $urandom; RD2D = $urandom; RD3D = $urandom;
            SignImmD = $urandom; PCPlus4D = $urandom;
            rsD = 5'($urandom_range(0, 31));
            rtD = 5'($urandom_range(0, 31));
            rdD = 5'($urandom_range(0, 31));
            cyc();
        end

        // Long flush run from the random state must trip the watchdog
        flushes(MAX_BUBBLES);
        chk("wd_final_trip", 32'(stuck_err), 32'd1);

        idle_inputs();
        cyc();
        mon_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
